// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer taking masked fetch groups at the tail
// and presenting up to DEQ_WIDTH head entries combinationally to decode.
module fetch_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEQ_WIDTH   = 4,
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                enq_valid_i,
  input  logic [FETCH_WIDTH-1:0]              enq_mask_i,
  input  logic [DATA_W-1:0]                   enq_pc_i,
  input  logic [FETCH_WIDTH*DATA_W-1:0]       enq_inst_i,
  output logic                                enq_ready_o,
  input  logic                                deq_stall_i,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]      deq_take_i,
  output logic [DEQ_WIDTH-1:0]                deq_valid_o,
  output logic [DEQ_WIDTH*DATA_W-1:0]         deq_inst_o,
  output logic [DEQ_WIDTH*DATA_W-1:0]         deq_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]          count_o,
  output logic                                empty_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int TAKE_W = $clog2(DEQ_WIDTH+1);

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] enq_cnt;
  logic [CNT_W-1:0] take_clamp;
  logic [CNT_W-1:0] deq_cnt;
  logic             enq_fire;

  // Masks are contiguous from slot 0, so the popcount is also the slot count.
  always_comb begin
    enq_cnt = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      enq_cnt = enq_cnt + CNT_W'(enq_mask_i[s]);
    end
  end

  // Readiness looks only at the registered count; a same-cycle dequeue earns no credit.
  assign enq_ready_o = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;

  always_comb begin
    take_clamp = '0;
    deq_cnt    = '0;
    if (deq_take_i > TAKE_W'(DEQ_WIDTH)) begin
      take_clamp = CNT_W'(DEQ_WIDTH);
    end else begin
      take_clamp = CNT_W'(deq_take_i);
    end
    if (!deq_stall_i && !flush_i) begin
      deq_cnt = (take_clamp < count_q) ? take_clamp : count_q;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(deq_cnt);
    tail_d  = tail_q;
    count_d = count_q - deq_cnt;
    if (enq_fire) begin
      tail_d  = tail_q + PTR_W'(enq_cnt);
      count_d = count_q + enq_cnt - deq_cnt;
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        if (enq_mask_i[s]) begin
          inst_mem[tail_q + PTR_W'(s)] <= enq_inst_i[s*DATA_W +: DATA_W];
          pc_mem[tail_q + PTR_W'(s)]   <= enq_pc_i + DATA_W'(4 * s);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEQ_WIDTH; gi++) begin : g_head
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx          = head_q + PTR_W'(gi);
      assign deq_valid_o[gi] = (CNT_W'(gi) < count_q);
      assign deq_inst_o[gi*DATA_W +: DATA_W] = deq_valid_o[gi] ? inst_mem[rd_idx] : '0;
      assign deq_pc_o[gi*DATA_W +: DATA_W]   = deq_valid_o[gi] ? pc_mem[rd_idx]   : '0;
    end
  endgenerate

  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int FW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 16;
  localparam int XW = 32;

  logic clk = 0, rst = 0, flush = 0, enq_valid = 0, deq_stall = 0;
  logic [FW-1:0] enq_mask = '0;
  logic [XW-1:0] enq_pc = '0;
  logic [FW*XW-1:0] enq_inst = '0;
  logic [2:0] deq_take = '0;
  logic enq_ready, empty;
  logic [DW-1:0] deq_valid;
  logic [DW*XW-1:0] deq_inst, deq_pc;
  logic [4:0] count;

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct packed {
    logic [XW-1:0] inst;
    logic [XW-1:0] pc;
  } ent_t;
  ent_t mq[$];

  fetch_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .enq_valid_i(enq_valid),
    .enq_mask_i(enq_mask), .enq_pc_i(enq_pc), .enq_inst_i(enq_inst),
    .enq_ready_o(enq_ready), .deq_stall_i(deq_stall), .deq_take_i(deq_take),
    .deq_valid_o(deq_valid), .deq_inst_o(deq_inst), .deq_pc_o(deq_pc),
    .count_o(count), .empty_o(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && enq_valid)
      assert (((enq_mask + 4'd1) & enq_mask) == 4'd0)
        else $error("illegal non-contiguous enq_mask %b", enq_mask);
  end

  // Reference model: a queue of entries updated once per clock edge.
  task automatic model_step();
    int n, taken;
    bit ready;
    if (flush) begin
      mq.delete();
      return;
    end
    ready = (DEPTH - mq.size()) >= FW;
    if (!deq_stall) begin
      taken = (deq_take > DW) ? DW : int'(deq_take);
      if (taken > mq.size()) taken = mq.size();
      repeat (taken) void'(mq.pop_front());
    end
    n = 0;
    for (int s = 0; s < FW; s++) n += int'(enq_mask[s]);
    if (enq_valid && ready)
      for (int s = 0; s < n; s++)
        mq.push_back({enq_inst[s*XW +: XW], enq_pc + 32'(4 * s)});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_valid();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW; i++) if (i < mq.size()) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW*XW-1:0] exp_inst();
    logic [DW*XW-1:0] r = '0;
    for (int i = 0; i < DW; i++) if (i < mq.size()) r[i*XW +: XW] = mq[i].inst;
    return r;
  endfunction

  function automatic logic [DW*XW-1:0] exp_pc();
    logic [DW*XW-1:0] r = '0;
    for (int i = 0; i < DW; i++) if (i < mq.size()) r[i*XW +: XW] = mq[i].pc;
    return r;
  endfunction

  task automatic idle();
    enq_valid = 0; flush = 0; deq_stall = 0; deq_take = '0; enq_mask = '0;
  endtask

  task automatic group(input logic [FW-1:0] m, input logic [XW-1:0] pc, input logic [XW-1:0] ib);
    enq_valid = 1; enq_mask = m; enq_pc = pc;
    for (int s = 0; s < FW; s++) enq_inst[s*XW +: XW] = ib + 32'(s);
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #2 rst = 1;
    #1;
    chk_cnt++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
    chk_cnt++; if (deq_valid !== 4'd0) $display("FAIL reset_valid got=%b exp=0000", deq_valid); else pass_cnt++;
    chk_cnt++; if (deq_inst !== '0 || deq_pc !== '0) $display("FAIL reset_data inst=%h pc=%h exp=0", deq_inst, deq_pc); else pass_cnt++;
    chk_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else pass_cnt++;
    chk_cnt++; if (enq_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", enq_ready); else pass_cnt++;
    @(posedge clk);
    #1 rst = 0;
    mq.delete();
  endtask

  task automatic test_basic();
    group(4'hF, 32'h100, 32'hA0A0_0000);
    #1;
    chk_cnt++; if (deq_valid !== 4'd0) $display("FAIL basic_nobypass got=%b exp=0000", deq_valid); else pass_cnt++;
    tick();
    idle();
    chk_cnt++; if (count !== 5'd4) $display("FAIL basic_count got=%0d exp=4", count); else pass_cnt++;
    chk_cnt++; if (deq_valid !== 4'hF) $display("FAIL basic_valid got=%b exp=1111", deq_valid); else pass_cnt++;
    chk_cnt++; if (deq_pc !== {32'h10C, 32'h108, 32'h104, 32'h100}) $display("FAIL basic_pc got=%h exp=10c/108/104/100", deq_pc); else pass_cnt++;
    chk_cnt++; if (deq_inst !== {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}) $display("FAIL basic_inst got=%h", deq_inst); else pass_cnt++;
    deq_take = 3'd4;
    tick();
    idle();
    chk_cnt++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL basic_drain count=%0d empty=%b exp=0/1", count, empty); else pass_cnt++;
  endtask

  task automatic test_fill();
    deq_stall = 1; deq_take = 3'd4;
    for (int g = 0; g < 4; g++) begin
      group(4'hF, 32'h1000 + 32'(16 * g), 32'hB000_0000 + 32'(16 * g));
      tick();
    end
    chk_cnt++; if (count !== 5'd16) $display("FAIL fill_count got=%0d exp=16", count); else pass_cnt++;
    chk_cnt++; if (enq_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", enq_ready); else pass_cnt++;
    group(4'hF, 32'h1040, 32'hB000_0040);
    tick();
    chk_cnt++; if (count !== 5'd16) $display("FAIL fill_held got=%0d exp=16", count); else pass_cnt++;
    chk_cnt++; if (deq_pc[XW-1:0] !== 32'h1000) $display("FAIL fill_stall_head got=%h exp=1000", deq_pc[XW-1:0]); else pass_cnt++;
    deq_stall = 0;
    tick();
    idle();
    chk_cnt++; if (count !== 5'd12) $display("FAIL fill_deq_count got=%0d exp=12", count); else pass_cnt++;
    chk_cnt++; if (enq_ready !== 1'b1) $display("FAIL fill_deq_ready got=%b exp=1", enq_ready); else pass_cnt++;
    chk_cnt++; if (deq_pc[XW-1:0] !== 32'h1010) $display("FAIL fill_deq_head got=%h exp=1010", deq_pc[XW-1:0]); else pass_cnt++;
    deq_take = 3'd4;
    repeat (3) tick();
    idle();
    chk_cnt++; if (empty !== 1'b1) $display("FAIL fill_drain empty=%b exp=1", empty); else pass_cnt++;
  endtask

  task automatic test_partial();
    group(4'b0011, 32'h200, 32'hC000_0000);
    tick();
    group(4'hF, 32'h210, 32'hC000_0010);
    tick();
    idle();
    chk_cnt++; if (count !== 5'd6) $display("FAIL partial_count got=%0d exp=6", count); else pass_cnt++;
    chk_cnt++; if (deq_pc !== {32'h214, 32'h210, 32'h204, 32'h200}) $display("FAIL partial_pc got=%h exp=214/210/204/200", deq_pc); else pass_cnt++;
    deq_take = 3'd3;
    tick();
    idle();
    chk_cnt++; if (deq_pc[XW-1:0] !== 32'h214 || count !== 5'd3) $display("FAIL partial_take pc0=%h count=%0d exp=214/3", deq_pc[XW-1:0], count); else pass_cnt++;
    deq_take = 3'd4;
    tick();
    idle();
    chk_cnt++; if (empty !== 1'b1) $display("FAIL partial_drain empty=%b exp=1", empty); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 20; c++) begin
      group(4'hF, 32'h3000 + 32'(16 * c), 32'hD000_0000 + 32'(16 * c));
      deq_take = 3'd3;
      tick();
      chk_cnt++;
      if (count !== 5'(mq.size()) || deq_valid !== exp_valid() || deq_pc !== exp_pc() || deq_inst !== exp_inst())
        $display("FAIL wrap_c%0d count=%0d exp=%0d pc=%h exp_pc=%h", c, count, mq.size(), deq_pc, exp_pc());
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    idle();
    deq_stall = 1;
    group(4'hF, 32'h400, 32'hE000_0000); tick();
    group(4'hF, 32'h410, 32'hE000_0010); tick();
    group(4'b0001, 32'h420, 32'hE000_0020); tick();
    chk_cnt++; if (count !== 5'd9) $display("FAIL flush_pre_count got=%0d exp=9", count); else pass_cnt++;
    group(4'hF, 32'h430, 32'hE000_0030);
    deq_stall = 0; deq_take = 3'd2; flush = 1;
    tick();
    idle();
    chk_cnt++; if (count !== 5'd0 || empty !== 1'b1 || deq_valid !== 4'd0) $display("FAIL flush_clear count=%0d empty=%b valid=%b exp=0/1/0000", count, empty, deq_valid); else pass_cnt++;
    group(4'b0011, 32'h500, 32'hE000_0100);
    tick();
    idle();
    chk_cnt++; if (count !== 5'd2 || deq_pc[2*XW-1:0] !== {32'h504, 32'h500}) $display("FAIL flush_reenq count=%0d pc=%h exp=2/504,500", count, deq_pc[2*XW-1:0]); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    group(4'hF, 32'h600, 32'hF000_0000); tick();
    group(4'b0001, 32'h610, 32'hF000_0010); tick();
    idle();
    chk_cnt++; if (count !== 5'd7) $display("FAIL areset_pre_count got=%0d exp=7", count); else pass_cnt++;
    #2 rst = 1;
    #1;
    chk_cnt++; if (count !== 5'd0 || deq_valid !== 4'd0 || deq_pc !== '0 || deq_inst !== '0) $display("FAIL areset_outputs count=%0d valid=%b", count, deq_valid); else pass_cnt++;
    chk_cnt++; if (empty !== 1'b1 || enq_ready !== 1'b1) $display("FAIL areset_flags empty=%b ready=%b exp=1/1", empty, enq_ready); else pass_cnt++;
    #1 rst = 0;
    mq.delete();
    group(4'b0011, 32'h700, 32'hF000_0100);
    tick();
    idle();
    chk_cnt++; if (count !== 5'd2) $display("FAIL areset_reenq got=%0d exp=2", count); else pass_cnt++;
    deq_take = 3'd4;
    tick();
    idle();
    chk_cnt++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL underflow count=%0d empty=%b exp=0/1", count, empty); else pass_cnt++;
  endtask

  task automatic test_random();
    int n;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 99) < 3);
      enq_valid = ($urandom_range(0, 99) < 70);
      n         = $urandom_range(0, 4);
      enq_mask  = 4'((1 << n) - 1);
      enq_pc    = {$urandom_range(0, 32'hFFFF), 2'b00};
      for (int s = 0; s < FW; s++) enq_inst[s*XW +: XW] = $urandom;
      deq_stall = ($urandom_range(0, 99) < 20);
      deq_take  = 3'($urandom_range(0, 7));
      tick();
      chk_cnt++;
      if (count !== 5'(mq.size()) || deq_valid !== exp_valid() || deq_pc !== exp_pc() ||
          deq_inst !== exp_inst() || empty !== (mq.size() == 0) || enq_ready !== ((DEPTH - mq.size()) >= FW))
        $display("FAIL random_c%0d count=%0d exp=%0d valid=%b exp=%b pc=%h exp=%h", c, count, mq.size(), deq_valid, exp_valid(), deq_pc, exp_pc());
      else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_partial();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
